// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and
// the bit-counter width helper.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int unsigned WIDTH_MIN = 1;
  localparam int unsigned WIDTH_MAX = 32;

  // Bits needed to count 0..width-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d_c,
  output logic bout_c
);

  assign d_c    = a ^ b ^ bin;
  // Borrow when the minuend bit cannot cover the subtrahend plus incoming borrow.
  assign bout_c = (~a & (b | bin)) | (b & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - borrow_in, LSB first, one full_subtractor cell and a
// registered borrow; result and final borrow hold until the next completion.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_next;
  logic             brw;
  logic [CNT_W-1:0] cnt;
  logic             cell_d;
  logic             cell_b;

  full_subtractor u_cell (
    .a      (a_sh[0]),
    .b      (b_sh[0]),
    .bin    (brw),
    .d_c    (cell_d),
    .bout_c (cell_b)
  );

  // Result register fills from the top so the LSB lands at bit 0 last.
  if (WIDTH == 1) begin : g_res_w1
    assign res_next = cell_d;
  end else begin : g_res_wn
    assign res_next = {cell_d, res_sh[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      a_sh       <= '0;
      b_sh       <= '0;
      res_sh     <= '0;
      brw        <= 1'b0;
      cnt        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          busy <= 1'b0;
          done <= 1'b0;
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            brw    <= borrow_in;
            cnt    <= '0;
            res_sh <= '0;
            busy   <= 1'b1;
            state  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          res_sh <= res_next;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          brw    <= cell_b;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            diff       <= res_next;
            borrow_out <= cell_b;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
